// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg: MDU control-word bit positions, sequencer FSM states and the
// arithmetic result bundle shared by the sequencer and its arithmetic unit.
package mdu_sequencer_pkg;
    localparam int MDU_LAUNCH = 4;
    localparam int MDU_DIV    = 3;
    localparam int MDU_UNS    = 2;
    localparam int MDU_MOVE   = 1;
    localparam int MDU_LO     = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational mult/multu/div/divu producing {hi,lo}; valid drops for a
// zero divisor so the sequencer can leave HI/LO untouched.
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        divide_i,
    input  logic        unsigned_i,
    output mdu_res_t    res_o
);
    logic [63:0] a_x, b_x, prod;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;
    logic        a_neg, b_neg, b_zero;

    // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_neg       = ~unsigned_i & a_i[31];
        b_neg       = ~unsigned_i & b_i[31];
        b_zero      = (b_i == 32'd0);
        a_x         = {{32{a_neg}}, a_i};
        b_x         = {{32{b_neg}}, b_i};
        prod        = a_x * b_x;
        a_mag       = a_neg ? -a_i : a_i;
        b_mag       = b_neg ? -b_i : b_i;
        b_div       = b_zero ? 32'd1 : b_mag;
        q_mag       = a_mag / b_div;
        r_mag       = a_mag % b_div;
        res_o.valid = ~(divide_i & b_zero);
        res_o.lo    = divide_i ? ((a_neg ^ b_neg) ? -q_mag : q_mag) : prod[31:0];
        res_o.hi    = divide_i ? (a_neg ? -r_mag : r_mag) : prod[63:32];
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: launches MDU operations, models their latency, owns HI/LO and
// raises the EX stall while the unit is occupied.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ctrl,
    input  logic        mdu_instr,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);
    localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    mdu_res_t      pend_q, pend_d, arith;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          move, commit;

    mdu_arith u_arith (
        .a_i       (A),
        .b_i       (B),
        .divide_i  (ctrl[MDU_DIV]),
        .unsigned_i(ctrl[MDU_UNS]),
        .res_o     (arith)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Start and Busy are mutually exclusive, so a launch never lands on the commit edge.
    always_comb begin
        Busy    = (state_q == RUN);
        Start   = ctrl[MDU_LAUNCH] & ~Busy & ~cancel & ~reset;
        move    = ~ctrl[MDU_LAUNCH] & ctrl[MDU_MOVE] & ~cancel & ~Busy;
        commit  = Busy & (count_q == CW'(1));
        state_d = Start ? RUN : (commit ? IDLE : state_q);
        count_d = Start ? (ctrl[MDU_DIV] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES))
                        : (Busy ? count_q - CW'(1) : count_q);
        pend_d  = Start ? arith : pend_q;
        hi_d    = (commit & pend_q.valid) ? pend_q.hi : ((move & ~ctrl[MDU_LO]) ? A : hi_q);
        lo_d    = (commit & pend_q.valid) ? pend_q.lo : ((move & ctrl[MDU_LO]) ? A : lo_q);
        stall   = (Start | Busy) & mdu_instr;
        HI      = hi_q;
        LO      = lo_q;
        mdu_out = ctrl[MDU_LO] ? lo_q : hi_q;
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors against a cycle-level behavioural model of the MDU,
// plus literal checks of the hand-computed results.
module tb_mdu_sequencer;
    logic        clk = 1'b0, reset = 1'b1, mdu_instr = 1'b0, cancel = 1'b0;
    logic [4:0]  ctrl = '0;
    logic [31:0] A = '0, B = '0;
    logic        Start, Busy, stall;
    logic [31:0] HI, LO, mdu_out;

    int          vectors = 0, errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [64:0] m_pend = '0;
    int          m_cnt = 0;

    localparam logic [4:0] MULT = 5'b10000, MULTU = 5'b10100, DIV = 5'b11000, DIVU = 5'b11100;
    localparam logic [4:0] MTHI = 5'b00010, MTLO = 5'b00011, MFHI = 5'b00000, MFLO = 5'b00001;

    mdu_sequencer dut (
        .clk(clk), .reset(reset), .ctrl(ctrl), .mdu_instr(mdu_instr), .cancel(cancel),
        .A(A), .B(B), .Start(Start), .Busy(Busy), .stall(stall),
        .HI(HI), .LO(LO), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] op_model(input logic dv, us, input logic [31:0] a, b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, r;
        logic [63:0] p;
        if (!dv) begin
            p = us ? 64'(a) * 64'(b) : 64'(sa * sb);
            return {1'b1, p};
        end
        if (b == 32'd0) return {1'b0, 64'd0};
        if (us) return {1'b1, a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {1'b1, 32'(r), 32'(q)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_pend = '0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0 && m_pend[64]) begin
                m_hi = m_pend[63:32];
                m_lo = m_pend[31:0];
            end
        end else if (ctrl[4] && !cancel) begin
            m_pend = op_model(ctrl[3], ctrl[2], A, B);
            m_cnt  = ctrl[3] ? 10 : 5;
        end else if (ctrl[1] && !cancel) begin
            if (ctrl[0]) m_lo = A;
            else m_hi = A;
        end
    end

    always @(negedge clk) begin
        logic        es, eb, est;
        logic [31:0] eo;
        es  = ctrl[4] && m_cnt == 0 && !cancel && !reset;
        eb  = m_cnt != 0;
        est = (es || eb) && mdu_instr;
        eo  = ctrl[0] ? m_lo : m_hi;
        vectors++;
        if ({Start, Busy, stall, HI, LO, mdu_out} !== {es, eb, est, m_hi, m_lo, eo}) begin
            errors++;
            $display("FAIL model t=%0t start/busy/stall got %b%b%b exp %b%b%b HI got %h exp %h LO got %h exp %h out got %h exp %h",
                     $time, Start, Busy, stall, es, eb, est, HI, m_hi, LO, m_lo, mdu_out, eo);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] c, input logic mi, cn, input logic [31:0] a, b);
        @(posedge clk);
        #2;
        ctrl = c; mdu_instr = mi; cancel = cn; A = a; B = b;
        #1;
    endtask

    task automatic run_out(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
            if (!Busy) return;
            n++;
        end
        chk("busy_bound", 32'(n), 32'd0);
    endtask

    typedef struct {logic [4:0] c; logic [31:0] a, b;} vec_t;
    vec_t table_v[6] = '{
        '{MULT, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF},
        '{DIVU, 32'hFFFFFFFF, 32'd10},       '{DIV, 32'd7, 32'hFFFFFFFD},
        '{MULT, 32'h80000000, 32'd2},         '{DIVU, 32'd5, 32'd9}
    };

    initial begin
        int n, ns;
        ctrl = MULT;
        @(posedge clk);
        #3;
        chk("start_in_reset", 32'(Start), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0; ctrl = '0;

        drive(MULT, 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3);
        chk("t1_start", 32'(Start), 32'd1);
        run_out(n);
        chk("t1_busy_len", 32'(n), 32'd5);
        chk("t1_hi", HI, 32'hFFFFFFFF);
        chk("t1_lo", LO, 32'hFFFFFFFA);

        drive(DIVU, 1'b1, 1'b0, 32'd7, 32'd2);
        ns = 0;
        for (int i = 0; i < 10; i++) begin
            drive(MFLO, 1'b1, 1'b0, 32'd0, 32'd0);
            ns += int'(stall);
        end
        drive(MFLO, 1'b1, 1'b0, 32'd0, 32'd0);
        chk("t2_stall_cycles", 32'(ns), 32'd10);
        chk("t2_stall_after", 32'(stall), 32'd0);
        chk("t2_mdu_out", mdu_out, 32'd3);
        chk("t2_hi", HI, 32'd1);

        drive(DIV, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_out(n);
        chk("t3_ovf_lo", LO, 32'h80000000);
        chk("t3_ovf_hi", HI, 32'd0);
        drive(DIV, 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
        run_out(n);
        chk("t3_neg_lo", LO, 32'hFFFFFFFD);
        chk("t3_neg_hi", HI, 32'hFFFFFFFF);

        drive(MTHI, 1'b1, 1'b1, 32'h1234, 32'd0);
        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t4_cancel_hi", HI, 32'hFFFFFFFF);
        drive(MTHI, 1'b1, 1'b0, 32'h1234, 32'd0);
        chk("t4_no_stall", 32'(stall), 32'd0);
        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t4_hi", HI, 32'h1234);
        drive(MULT, 1'b1, 1'b1, 32'd2, 32'd3);
        chk("t4_cancel_start", 32'(Start), 32'd0);

        drive(MULT, 1'b1, 1'b0, 32'd2, 32'd3);
        drive(MTLO, 1'b1, 1'b1, 32'h99, 32'd0);
        drive(MTLO, 1'b1, 1'b0, 32'h99, 32'd0);
        run_out(n);
        chk("cancel_in_run_lo", LO, 32'd6);
        drive(MTLO, 1'b1, 1'b0, 32'h99, 32'd0);
        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("move_after_busy", LO, 32'h99);

        drive(MULT, 1'b1, 1'b0, 32'd5, 32'd7);
        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_busy", 32'(Busy), 32'd0);
        chk("t5_hi", HI, 32'd0);
        chk("t5_lo", LO, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(MTLO, 1'b0, 1'b0, 32'h55, 32'd0);
        drive(DIV, 1'b1, 1'b0, 32'd9, 32'd0);
        run_out(n);
        chk("t5_div0_len", 32'(n), 32'd10);
        chk("t5_div0_lo", LO, 32'h55);
        chk("t5_div0_hi", HI, 32'd0);

        drive(MULT, 1'b1, 1'b0, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) drive(MULTU, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2);
        drive(MULTU, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd2);
        chk("t6_second_start", 32'(Start), 32'd1);
        chk("t6_first_lo", LO, 32'd12);
        run_out(n);
        chk("t6_busy_len", 32'(n), 32'd5);
        chk("t6_hi", HI, 32'd1);
        chk("t6_lo", LO, 32'hFFFFFFFE);

        foreach (table_v[i]) begin
            drive(table_v[i].c, 1'b1, 1'b0, table_v[i].a, table_v[i].b);
            run_out(n);
        end
        chk("tbl_last_lo", LO, 32'd0);
        chk("tbl_last_hi", HI, 32'd5);

        drive(MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
